// File: rtl/bf16_vec_collector.sv
// bf16_vec_collector: packs a valid/ready stream of BF16 scalars into
// k-element blocks for the MXINT8 converter. It tracks the largest raw
// exponent field while the block fills. A fill bank and an output bank
// let the next block stream in while the converter drains the current one.
module bf16_vec_collector #(
  parameter  int k     = 32,
  localparam int cnt_w = $clog2(k + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [15:0]        i_bf16,
  input  logic               i_valid,
  input  logic               i_last,
  output logic               o_ready,
  output logic [16*k-1:0]    o_bf16_vec,
  output logic [7:0]         o_e_max,
  output logic [cnt_w-1:0]   o_n_elems,
  output logic               o_valid,
  input  logic               i_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Fill bank: slots are cleared when a block leaves, so any slot that is
  // never written is already the zero pad.
  logic [k-1:0][15:0] fill_vec;
  logic [cnt_w-1:0]   cnt;
  logic [7:0]         fmax;

  // Output bank
  logic [k-1:0][15:0] out_vec;

  // Block as it would leave the fill bank this cycle, including any
  // element accepted in the same cycle.
  logic [k-1:0][15:0] blk_vec;
  logic [7:0]         blk_max;
  logic [cnt_w-1:0]   blk_n;

  logic accept;
  logic complete;
  logic out_free;
  logic consume;
  logic xfer;

  // Unsigned compare on the raw exponent field. 0xFF (Inf/NaN) wins naturally.
  function automatic logic [7:0] exp_max(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // o_ready is a pure state decode so that i_ready never reaches it combinationally.
  assign o_ready  = (state == FILL);
  assign accept   = i_valid & o_ready;
  assign complete = accept & ((cnt == cnt_w'(k - 1)) | i_last);
  assign consume  = o_valid & i_ready;
  assign out_free = ~o_valid | i_ready;

  assign o_bf16_vec = out_vec;

  // Merge the element being accepted into the fill bank image and update the running max.
  always_comb begin
    blk_vec = fill_vec;
    blk_max = fmax;
    blk_n   = cnt;
    if (accept) begin
      for (int i = 0; i < k; i++) begin
        if (cnt == cnt_w'(i)) begin
          blk_vec[i] = i_bf16;
        end
      end
      blk_max = exp_max(fmax, i_bf16[14:7]);
      blk_n   = cnt + cnt_w'(1);
    end
  end

  // FSM next-state logic and bank-transfer decision.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    case (state)
      FILL: begin
        if (complete) begin
          if (out_free) begin
            xfer = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          xfer      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill bank: capture accepted elements. Restart empty once the block moves out.
  // In HOLD, cnt keeps the completed block's element count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fill_vec <= '0;
      cnt      <= '0;
      fmax     <= '0;
    end else if (xfer) begin
      fill_vec <= '0;
      cnt      <= '0;
      fmax     <= '0;
    end else if (accept) begin
      fill_vec <= blk_vec;
      cnt      <= blk_n;
      fmax     <= blk_max;
    end
  end

  // Output bank: load on transfer, hold while stalled, drop valid after a plain consume.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_vec   <= '0;
      o_e_max   <= '0;
      o_n_elems <= '0;
      o_valid   <= 1'b0;
    end else if (xfer) begin
      out_vec   <= blk_vec;
      o_e_max   <= blk_max;
      o_n_elems <= blk_n;
      o_valid   <= 1'b1;
    end else if (consume) begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf16_vec_collector.sv
// Testbench for bf16_vec_collector: directed scenarios plus a long random run.
// All scenarios are checked against a queue-based block model.
module tb_bf16_vec_collector;

  localparam int K  = 32;
  localparam int CW = $clog2(K + 1);
  localparam int VW = 16 * K;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld   = 1'b0;
  logic          last  = 1'b0;
  logic          rdy   = 1'b0;
  logic [15:0]   din   = '0;
  logic          o_ready;
  logic          o_valid;
  logic [VW-1:0] o_vec;
  logic [7:0]    o_emax;
  logic [CW-1:0] o_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [VW-1:0] vec;
    logic [7:0]    emax;
    logic [CW-1:0] n;
  } blk_t;

  blk_t        exq[$];
  logic [15:0] cur[$];
  int          n_acc  = 0;
  int          n_cons = 0;

  bf16_vec_collector #(.k(K)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_bf16     (din),
    .i_valid    (vld),
    .i_last     (last),
    .o_ready    (o_ready),
    .o_bf16_vec (o_vec),
    .o_e_max    (o_emax),
    .o_n_elems  (o_n),
    .o_valid    (o_valid),
    .i_ready    (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs with the model, advance the model with the current inputs, then clock.
  task automatic step();
    logic m_valid;
    logic m_ready;
    blk_t b;
    m_valid = (exq.size() > 0);
    m_ready = (exq.size() < 2);
    chk("o_valid", VW'(o_valid), VW'(m_valid));
    chk("o_ready", VW'(o_ready), VW'(m_ready));
    if (m_valid) begin
      chk("vec", o_vec, exq[0].vec);
      chk("e_max", VW'(o_emax), VW'(exq[0].emax));
      chk("n_elems", VW'(o_n), VW'(exq[0].n));
    end
    if (!rst_n) begin
      exq.delete();
      cur.delete();
    end else begin
      if (m_valid && rdy) begin
        b = exq.pop_front();
        n_cons++;
      end
      if (vld && m_ready) begin
        cur.push_back(din);
        n_acc++;
        if (cur.size() == K || last) begin
          b.vec  = '0;
          b.emax = '0;
          b.n    = CW'(cur.size());
          foreach (cur[i]) begin
            b.vec[16*i +: 16] = cur[i];
            if (cur[i][14:7] > b.emax) b.emax = cur[i][14:7];
          end
          exq.push_back(b);
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] d, input logic l, input logic r);
    vld  = 1'b1;
    din  = d;
    last = l;
    rdy  = r;
    step();
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      vld  = 1'b0;
      last = 1'b0;
      rdy  = r;
      step();
    end
  endtask

  initial begin
    logic [15:0]   arr[70];
    logic [7:0]    e;
    logic [7:0]    emax_exp;
    logic [VW-1:0] vexp;
    int            base;
    int            cbase;
    int            guard;

    // Reset
    rst_n = 1'b0;
    idle(1'b0, 2);
    rst_n = 1'b1;
    chk("rst_valid", VW'(o_valid), VW'(1'b0));
    chk("rst_ready", VW'(o_ready), VW'(1'b1));
    chk("rst_emax", VW'(o_emax), VW'(8'h00));
    chk("rst_n", VW'(o_n), VW'(0));
    chk("rst_vec", o_vec, '0);

    // 32 x 1.0
    for (int i = 0; i < K; i++) feed(16'h3F80, 1'b0, 1'b1);
    chk("t1_valid", VW'(o_valid), VW'(1'b1));
    chk("t1_emax", VW'(o_emax), VW'(8'h7F));
    chk("t1_n", VW'(o_n), VW'(32));
    idle(1'b1, 2);

    // Ascending exponents, then a block with a single 0xFF at slot 5
    base = n_acc;
    for (int i = 0; i < K; i++) begin
      e = 8'h70 + 8'(i);
      feed({1'($urandom), e, 7'($urandom)}, 1'b0, 1'b1);
    end
    chk("t2a_emax", VW'(o_emax), VW'(8'h8F));
    chk("t2a_n", VW'(o_n), VW'(32));
    for (int i = 0; i < K; i++) begin
      e = (i == 5) ? 8'hFF : 8'($urandom_range(0, 254));
      feed({1'($urandom), e, 7'($urandom)}, 1'b0, 1'b1);
    end
    chk("t2b_emax", VW'(o_emax), VW'(8'hFF));
    chk("t2_contig", VW'(n_acc - base), VW'(64));
    idle(1'b1, 2);

    // Short block closed by i_last
    feed({1'b0, 8'h80, 7'h11}, 1'b0, 1'b1);
    feed({1'b1, 8'h85, 7'h22}, 1'b0, 1'b1);
    feed({1'b0, 8'h81, 7'h33}, 1'b1, 1'b1);
    chk("t3_n", VW'(o_n), VW'(3));
    chk("t3_emax", VW'(o_emax), VW'(8'h85));
    chk("t3_pad", o_vec >> 48, '0);
    chk("t3_slot0", VW'(o_vec[15:0]), VW'({1'b0, 8'h80, 7'h11}));
    idle(1'b1, 2);

    // Backpressure: 100 cycles of i_ready=0 while offering 70 elements
    foreach (arr[i]) arr[i] = 16'($urandom);
    base  = n_acc;
    cbase = n_cons;
    for (int c = 0; c < 100; c++) begin
      if (n_acc - base < 70) feed(arr[n_acc - base], 1'b0, 1'b0);
      else idle(1'b0, 1);
    end
    chk("t4_accepted", VW'(n_acc - base), VW'(64));
    chk("t4_ready", VW'(o_ready), VW'(1'b0));
    chk("t4_valid", VW'(o_valid), VW'(1'b1));
    vexp     = '0;
    emax_exp = '0;
    for (int i = 0; i < K; i++) begin
      vexp[16*i +: 16] = arr[i];
      if (arr[i][14:7] > emax_exp) emax_exp = arr[i][14:7];
    end
    chk("t4_first_vec", o_vec, vexp);
    chk("t4_first_emax", VW'(o_emax), VW'(emax_exp));
    guard = 0;
    while (n_acc - base < 70 && guard < 40) begin
      feed(arr[n_acc - base], (n_acc - base) == 69, 1'b1);
      guard++;
    end
    idle(1'b1, 4);
    chk("t4_all_in", VW'(n_acc - base), VW'(70));
    chk("t4_blocks_out", VW'(n_cons - cbase), VW'(3));

    // Reset in the middle of a block
    for (int i = 0; i < 10; i++) feed({1'b0, 8'hF0, 7'h05}, 1'b0, 1'b1);
    vld   = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_valid", VW'(o_valid), VW'(1'b0));
    chk("t5_ready", VW'(o_ready), VW'(1'b1));
    emax_exp = '0;
    for (int i = 0; i < K; i++) begin
      e = 8'($urandom_range(16, 64));
      if (e > emax_exp) emax_exp = e;
      feed({1'($urandom), e, 7'($urandom)}, 1'b0, 1'b1);
    end
    chk("t5_emax", VW'(o_emax), VW'(emax_exp));
    chk("t5_n", VW'(o_n), VW'(32));
    idle(1'b1, 2);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      vld  = ($urandom_range(0, 9) < 8);
      rdy  = ($urandom_range(0, 9) < 7);
      last = ($urandom_range(0, 19) == 0);
      e    = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
      din  = {1'($urandom), e, 7'($urandom)};
      step();
    end
    idle(1'b1, 4);
    chk("drain_valid", VW'(o_valid), VW'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
